dcache_wb_scheduler: RTL and testbench
======================================

Name: dcache_wb_scheduler

Overview:
Victim write-back buffer and AXI write-channel scheduler, placed between d_cache and the AXI arbiter's write side.
- d_cache pushes whole evicted dirty lines in one cycle; the block queues them in FIFO order.
- It issues one INCR burst per line on AW/W/B.
- It reports address hits so d_cache refills cannot overtake a pending write-back of the same line.

Parameters:
DEPTH, 4, number of line entries (power of two, >=2)
LINE_WORDS, 8, 32-bit words per line (power of two, 2..16)
OFFSET_W, 5, byte-offset bits of a line (= log2(LINE_WORDS*4))

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
push_valid  in  1  d_cache offers an evicted line
push_ready  out  1  buffer can accept a line this cycle
push_addr  in  32  physical line address (offset bits ignored)
push_data  in  LINE_WORDS*32  line data, word 0 in bits [31:0]
query_addr  in  32  physical address of the pending d_cache refill
query_hit  out  1  the line matching query_addr is queued or in flight
empty  out  1  no entries and no burst outstanding
awaddr  out  32  burst address, offset bits forced to 0
awlen  out  4  LINE_WORDS-1
awsize  out  3  3'b010
awvalid  out  1  AW request
awready  in  1  AW accept
wdata  out  32  current beat data
wstrb  out  4  4'hf
wlast  out  1  final beat
wvalid  out  1  W beat valid
wready  in  1  W accept
bvalid  in  1  write response valid
bready  out  1  response accept

Behaviour:
- Reset is asynchronous and active-high on rst. Single clock, clk.
- On reset: count=0, head=0, tail=0, state=IDLE, beat=0, awvalid=0, wvalid=0, wlast=0, bready=0, push_ready=1, empty=1, query_hit=0.
- push_ready = (count != DEPTH). It is derived from the registered count only, so a pop in the same cycle does not open a slot.
- Push fires on push_valid & push_ready. The entry is written at tail, tail increments modulo DEPTH, count increments.
- Pop happens at B completion (bvalid & bready): head increments and count decrements.
- Push and pop in the same cycle leave count unchanged.
- FSM:
  - IDLE: if count!=0, go to AW. awaddr = head address with offset cleared.
  - AW: awvalid=1. On awready, go to W with beat=0.
  - W: wvalid=1, wdata = head word[beat], wlast = (beat==LINE_WORDS-1). On wready: if wlast, go to B; else beat++.
  - B: bready=1. On bvalid, pop and go to IDLE.
- All AXI outputs are registered or decoded from state, never combinational from AXI inputs.
- Latency: a line pushed into an empty IDLE buffer at cycle t gets awvalid at t+2 (count visible at t+1, AW state at t+2).
- AW and W are strictly sequential: wvalid is never raised before the AW handshake.
- The head entry is not freed until B, so its data stays stable through the burst.
- query_hit is combinational: line-address compare of query_addr against every valid entry, including the in-flight head until its pop.
  - A push in the current cycle is not visible until the next cycle.
  - d_cache must stall a refill while query_hit=1.
- Duplicate lines (same address pushed twice) are legal. Both entries are kept and written back in order.
- bresp is ignored.
- empty = (count==0) && state==IDLE.
- Reset mid-burst: everything abandoned, all valids drop asynchronously.

Optional Feature:
WB_FWD_EN.
- Defined: adds output fwd_data[31:0]. It returns the word selected by query_addr[OFFSET_W-1:2] from the youngest matching valid entry.
- With the macro defined, query_hit means "forwardable", and d_cache may complete the read without waiting for the drain.
- Undefined: no fwd_data port; query_hit is stall-only.

Decomposition:
- Shared package (cpu_axi_pkg):
  - AXSIZE_WORD=3'b010, WSTRB_FULL=4'hf.
  - wb_state_t enum {IDLE, AW, W, B}.
  - line_addr function (clear offset bits).
- Natural sub-module: wb_line_fifo.
  - Storage arrays, head/tail/count, full/empty.
  - Parallel match vector for query_hit, plus youngest-match select when WB_FWD_EN is defined.
- dcache_wb_scheduler keeps the FSM and beat counter.

Test Plan:
- Single push addr 0x1fc0_0044, data words 0..7 = 0xA0..0xA7; awready/wready/bvalid always 1. Expect:
  - awaddr=0x1fc0_0040, awlen=7, awsize=2.
  - Eight beats 0xA0..0xA7 with wlast only on the 8th.
  - empty back to 1 after B.
- Push 5 lines with the slave stalled (awready=0). Expect:
  - push_ready=0 after the 4th push; the 5th is held.
  - Release: lines written in push order; the 5th is accepted the cycle after the first B.
- wready toggling 1,0,1,0 during a burst: beat advances only on handshake cycles, wdata stable while wready=0, still exactly 8 beats.
- Line 0x8000_1000 queued, query_addr=0x8000_101c → query_hit=1, held through W and B of that line, 0 the cycle after pop. query_addr=0x8000_1020 → 0.
- Full buffer with push_valid=1 on the same cycle as B pop: push rejected that cycle, accepted the next; count ends at DEPTH.
- Assert rst during the 3rd W beat: wvalid/awvalid/bready drop immediately, empty=1, push_ready=1. A new push afterward bursts normally.
- WB_FWD_EN defined: two pushes of line 0x100 (word3 = 0x11, then 0x22), query_addr=0x10c → fwd_data=0x22.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// -----------------------------------------------------------------------------
// cpu_axi_pkg
// Shared AXI constants, write-back scheduler state encoding and line-address
// helper used by dcache_wb_scheduler and its line FIFO.
//   AXSIZE_WORD : AxSIZE for 32-bit beats
//   WSTRB_FULL  : all byte lanes enabled
//   wb_state_t  : scheduler FSM encoding
//   line_addr() : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package cpu_axi_pkg;

    localparam logic [2:0] AXSIZE_WORD = 3'b010;
    localparam logic [3:0] WSTRB_FULL  = 4'hf;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_AW   = 2'd1,
        WB_W    = 2'd2,
        WB_B    = 2'd3
    } wb_state_t;

    function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                              input int unsigned offset_w);
        logic [31:0] mask;
        mask = (32'h1 << offset_w) - 32'h1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/dcache_wb_scheduler_line_fifo.sv
// -----------------------------------------------------------------------------
// wb_line_fifo
// Storage for evicted dirty lines awaiting write-back, in FIFO order, with a
// parallel line-address match against every occupied entry.
// Optional macro: WB_FWD_EN -- adds fwd_data, the queried word taken from the
// youngest matching entry.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push              write push_addr/push_data at tail (caller ensures !full)
//   pop               retire the head entry (caller ensures !empty)
//   query_addr        address compared against all occupied entries
//   query_hit         some occupied entry holds the queried line
//   fwd_data          (WB_FWD_EN) queried word from the youngest match
//   head_addr/data    oldest entry, stable until it is popped
//   full, empty       occupancy flags
// -----------------------------------------------------------------------------
module wb_line_fifo
    import cpu_axi_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 8,
    parameter int OFFSET_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [31:0]                push_addr,
    input  logic [LINE_WORDS*32-1:0]   push_data,
    input  logic                       pop,
    input  logic [31:0]                query_addr,
    output logic                       query_hit,
`ifdef WB_FWD_EN
    output logic [31:0]                fwd_data,
`endif
    output logic [31:0]                head_addr,
    output logic [LINE_WORDS*32-1:0]   head_data,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]              addr_mem [DEPTH];
    logic [LINE_WORDS*32-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [DEPTH-1:0] match_vec;
    logic [PTR_W-1:0] age_q;
    logic [31:0]      q_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign q_line    = line_addr(query_addr, OFFSET_W);

    // A slot is occupied when its distance from head is below count; the head
    // stays occupied until its B handshake, so in-flight lines still match.
    always_comb begin
        match_vec = '0;
        age_q     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_q        = PTR_W'(i) - head;
            match_vec[i] = ({1'b0, age_q} < count) &&
                           (line_addr(addr_mem[i], OFFSET_W) == q_line);
        end
    end

    assign query_hit = |match_vec;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0]    young_idx;
    logic [PTR_W-1:0]    idx_q;
    logic [OFFSET_W-3:0] q_word;

    // Walk oldest to youngest; the last match seen is the most recent copy.
    always_comb begin
        young_idx = head;
        idx_q     = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx_q = head + PTR_W'(k);
            if (match_vec[idx_q]) young_idx = idx_q;
        end
    end

    assign q_word   = query_addr[OFFSET_W-1:2];
    assign fwd_data = data_mem[young_idx][{q_word, 5'b0} +: 32];
`endif

endmodule

// File: rtl/dcache_wb_scheduler.sv
// -----------------------------------------------------------------------------
// dcache_wb_scheduler
// Victim write-back buffer between d_cache and the AXI write channel. Whole
// dirty lines are queued in one cycle and drained in order as one INCR burst
// per line (AW, then LINE_WORDS W beats, then B). query_hit lets d_cache stall
// a refill of a line that is still queued or in flight.
// Optional macro: WB_FWD_EN -- adds fwd_data; query_hit then means the word
// can be forwarded from the buffer.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push_valid/ready/addr/data   line push from d_cache
//   query_addr, query_hit    refill hazard check (fwd_data with WB_FWD_EN)
//   empty                    nothing queued and no burst outstanding
//   aw*, w*, b*              AXI write address / data / response channels
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | no burst; start one when a line is queued
// AW    | awvalid high for the head line
// W     | streaming head words, beat selects the word
// B     | waiting for the response; head popped on bvalid
// -----------------------------------------------------------------------------
module dcache_wb_scheduler
    import cpu_axi_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LINE_WORDS = 8,
    parameter int OFFSET_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [31:0]                push_addr,
    input  logic [LINE_WORDS*32-1:0]   push_data,
    input  logic [31:0]                query_addr,
    output logic                       query_hit,
`ifdef WB_FWD_EN
    output logic [31:0]                fwd_data,
`endif
    output logic                       empty,
    output logic [31:0]                awaddr,
    output logic [3:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam int BEAT_W = $clog2(LINE_WORDS);

    localparam logic [1:0] ST_IDLE = WB_IDLE;
    localparam logic [1:0] ST_AW   = WB_AW;
    localparam logic [1:0] ST_W    = WB_W;
    localparam logic [1:0] ST_B    = WB_B;

    logic [1:0]              state;
    logic [BEAT_W-1:0]       beat;
    logic                    last_beat;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [31:0]             head_addr;
    logic [LINE_WORDS*32-1:0] head_data;

    // Ready comes from the registered count only: a same-cycle pop does not
    // open a slot, which keeps push_ready free of any AXI input path.
    assign push_ready = ~fifo_full;
    assign push       = push_valid & push_ready;
    assign pop        = bready & bvalid;

    wb_line_fifo #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .OFFSET_W   (OFFSET_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .pop        (pop),
        .query_addr (query_addr),
        .query_hit  (query_hit),
`ifdef WB_FWD_EN
        .fwd_data   (fwd_data),
`endif
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_AW;
                end
                ST_AW: begin
                    if (awready) begin
                        state <= ST_W;
                        beat  <= '0;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (last_beat) state <= ST_B;
                        else           beat  <= beat + 1'b1;
                    end
                end
                ST_B: begin
                    if (bvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Valids are pure state decodes so reset drops them without a clock edge.
    assign awvalid = (state == ST_AW);
    assign wvalid  = (state == ST_W);
    assign bready  = (state == ST_B);
    assign wlast   = wvalid & last_beat;

    assign awaddr  = line_addr(head_addr, OFFSET_W);
    assign awlen   = 4'(LINE_WORDS - 1);
    assign awsize  = AXSIZE_WORD;
    assign wdata   = head_data[{beat, 5'b0} +: 32];
    assign wstrb   = WSTRB_FULL;

    assign empty   = fifo_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_dcache_wb_scheduler.sv
module tb_dcache_wb_scheduler;

    localparam int DEPTH      = 4;
    localparam int LINE_WORDS = 8;
    localparam int OFFSET_W   = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      push_valid;
    logic                      push_ready;
    logic [31:0]               push_addr;
    logic [LINE_WORDS*32-1:0]  push_data;
    logic [31:0]               query_addr;
    logic                      query_hit;
`ifdef WB_FWD_EN
    logic [31:0]               fwd_data;
`endif
    logic                      empty;
    logic [31:0]               awaddr;
    logic [3:0]                awlen;
    logic [2:0]                awsize;
    logic                      awvalid;
    logic                      awready;
    logic [31:0]               wdata;
    logic [3:0]                wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic                      bvalid;
    logic                      bready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       nm;
        logic [31:0] q;
        logic        exp_hit;
    } qvec_t;
    qvec_t qv [5];

    dcache_wb_scheduler #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .OFFSET_W   (OFFSET_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_addr  (push_addr),
        .push_data  (push_data),
        .query_addr (query_addr),
        .query_hit  (query_hit),
`ifdef WB_FWD_EN
        .fwd_data   (fwd_data),
`endif
        .empty      (empty),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_WORDS*32-1:0] mk_line(input logic [31:0] base);
        logic [LINE_WORDS*32-1:0] l;
        for (int i = 0; i < LINE_WORDS; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        push_valid = 1'b0;
        push_addr  = '0;
        push_data  = '0;
        query_addr = 32'hffff_ffc0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_line(input logic [31:0] addr, input logic [31:0] base);
        push_valid = 1'b1;
        push_addr  = addr;
        push_data  = mk_line(base);
        step();
        push_valid = 1'b0;
    endtask

    // Expects awready/wready/bvalid held high by the caller.
    task automatic run_burst(input string nm, input logic [31:0] exp_aw, input logic [31:0] base);
        int n = 0;
        #1;
        while (!awvalid && n < 30) begin
            step();
            #1;
            n++;
        end
        chk({nm, "_aw_seen"}, 32'(awvalid), 32'd1);
        chk({nm, "_awaddr"}, awaddr, exp_aw);
        chk({nm, "_awlen"}, 32'(awlen), 32'd7);
        chk({nm, "_awsize"}, 32'(awsize), 32'd2);
        chk({nm, "_wvalid_in_aw"}, 32'(wvalid), 32'd0);
        step();
        for (int i = 0; i < LINE_WORDS; i++) begin
            chk({nm, "_wvalid"}, 32'(wvalid), 32'd1);
            chk({nm, "_wdata"}, wdata, base + 32'(i));
            chk({nm, "_wlast"}, 32'(wlast), (i == LINE_WORDS - 1) ? 32'd1 : 32'd0);
            chk({nm, "_wstrb"}, 32'(wstrb), 32'hf);
            step();
        end
        chk({nm, "_bready"}, 32'(bready), 32'd1);
        chk({nm, "_wvalid_in_b"}, 32'(wvalid), 32'd0);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        qv[0] = '{nm: "q_same_word7", q: 32'h8000_101c, exp_hit: 1'b1};
        qv[1] = '{nm: "q_line_base",  q: 32'h8000_1000, exp_hit: 1'b1};
        qv[2] = '{nm: "q_next_line",  q: 32'h8000_1020, exp_hit: 1'b0};
        qv[3] = '{nm: "q_prev_line",  q: 32'h8000_0fe0, exp_hit: 1'b0};
        qv[4] = '{nm: "q_high_alias", q: 32'h0000_1004, exp_hit: 1'b0};

        // ---------------- reset state + single line burst ----------------
        do_reset();
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_wlast", 32'(wlast), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_query_hit", 32'(query_hit), 32'd0);

        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        push_line(32'h1fc0_0044, 32'h0000_00a0);
        #1;
        chk("t1_awvalid_t1", 32'(awvalid), 32'd0);
        chk("t1_empty_t1", 32'(empty), 32'd0);
        step();
        chk("t1_awvalid_t2", 32'(awvalid), 32'd1);
        run_burst("t1", 32'h1fc0_0040, 32'h0000_00a0);
        #1;
        chk("t1_empty_end", 32'(empty), 32'd1);

        // ---------------- five lines against a stalled slave ----------------
        do_reset();
        wready = 1'b1;
        bvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_valid = 1'b1;
            push_addr  = 32'h2000_0000 + 32'(k * 'h40) + 32'(k * 4);
            push_data  = mk_line(32'h0000_0100 * 32'(k + 1));
            #1;
            chk("t2_push_ready_open", 32'(push_ready), 32'd1);
            step();
        end
        push_valid = 1'b1;
        push_addr  = 32'h2000_0100;
        push_data  = mk_line(32'h0000_0500);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("t2_push_ready_full", 32'(push_ready), 32'd0);
            chk("t2_aw_stalled", 32'(awvalid), 32'd1);
            step();
        end
        awready = 1'b1;
        run_burst("t2_l0", 32'h2000_0000, 32'h0000_0100);
        #1;
        chk("t2_slot_after_b", 32'(push_ready), 32'd1);
        step();
        push_valid = 1'b0;
        run_burst("t2_l1", 32'h2000_0040, 32'h0000_0200);
        run_burst("t2_l2", 32'h2000_0080, 32'h0000_0300);
        run_burst("t2_l3", 32'h2000_00c0, 32'h0000_0400);
        run_burst("t2_l4", 32'h2000_0100, 32'h0000_0500);
        #1;
        chk("t2_empty_end", 32'(empty), 32'd1);

        // ---------------- wready toggling 1,0,1,0 ----------------
        do_reset();
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        push_line(32'h3000_0080, 32'h0000_0300);
        begin
            int n = 0;
            int done = 0;
            int cyc = 0;
            #1;
            while (!awvalid && n < 20) begin
                step();
                #1;
                n++;
            end
            chk("t3_aw_seen", 32'(awvalid), 32'd1);
            step();
            while (done < LINE_WORDS && cyc < 40) begin
                wready = (cyc % 2 == 0);
                #1;
                chk("t3_wvalid", 32'(wvalid), 32'd1);
                chk("t3_wdata", wdata, 32'h0000_0300 + 32'(done));
                chk("t3_wlast", 32'(wlast), (done == LINE_WORDS - 1) ? 32'd1 : 32'd0);
                if (wready) done++;
                step();
                cyc++;
            end
            chk("t3_beats", 32'(done), 32'd8);
            wready = 1'b1;
            #1;
            chk("t3_bready", 32'(bready), 32'd1);
            chk("t3_no_extra_beat", 32'(wvalid), 32'd0);
            step();
            #1;
            chk("t3_empty_end", 32'(empty), 32'd1);
        end

        // ---------------- query_hit across the life of a line ----------------
        do_reset();
        query_addr = 32'h8000_101c;
        push_valid = 1'b1;
        push_addr  = 32'h8000_1000;
        push_data  = mk_line(32'h0000_0800);
        #1;
        chk("t4_hit_same_cycle_push", 32'(query_hit), 32'd0);
        step();
        push_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            query_addr = qv[i].q;
            #1;
            chk(qv[i].nm, 32'(query_hit), 32'(qv[i].exp_hit));
        end
        query_addr = 32'h8000_101c;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b0;
        begin
            int n = 0;
            while (!bready && n < 20) begin
                step();
                #1;
                chk("t4_hit_in_flight", 32'(query_hit), 32'd1);
                n++;
            end
            chk("t4_reached_b", 32'(bready), 32'd1);
        end
        step();
        #1;
        chk("t4_hit_b_wait", 32'(query_hit), 32'd1);
        chk("t4_b_held", 32'(bready), 32'd1);
        bvalid = 1'b1;
        #1;
        chk("t4_hit_pop_cycle", 32'(query_hit), 32'd1);
        step();
        bvalid = 1'b0;
        #1;
        chk("t4_hit_after_pop", 32'(query_hit), 32'd0);
        chk("t4_empty_end", 32'(empty), 32'd1);

        // ---------------- full buffer, push on the pop cycle ----------------
        do_reset();
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b0;
        for (int k = 0; k < 4; k++) push_line(32'h5000_0000 + 32'(k * 'h40), 32'h0000_0500 + 32'(k * 'h10));
        #1;
        chk("t5_full", 32'(push_ready), 32'd0);
        begin
            int n = 0;
            while (!bready && n < 20) begin
                step();
                #1;
                n++;
            end
            chk("t5_reached_b", 32'(bready), 32'd1);
        end
        push_valid = 1'b1;
        push_addr  = 32'h5000_0100;
        push_data  = mk_line(32'h0000_0540);
        bvalid     = 1'b1;
        #1;
        chk("t5_reject_on_pop", 32'(push_ready), 32'd0);
        step();
        bvalid = 1'b0;
        #1;
        chk("t5_accept_next", 32'(push_ready), 32'd1);
        step();
        push_valid = 1'b0;
        #1;
        chk("t5_full_again", 32'(push_ready), 32'd0);
        bvalid = 1'b1;
        run_burst("t5_l1", 32'h5000_0040, 32'h0000_0510);
        run_burst("t5_l2", 32'h5000_0080, 32'h0000_0520);
        run_burst("t5_l3", 32'h5000_00c0, 32'h0000_0530);
        run_burst("t5_l4", 32'h5000_0100, 32'h0000_0540);
        #1;
        chk("t5_empty_end", 32'(empty), 32'd1);

        // ---------------- reset during the 3rd W beat ----------------
        do_reset();
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        push_line(32'h6000_0040, 32'h0000_0600);
        push_line(32'h6000_0080, 32'h0000_0700);
        begin
            int n = 0;
            #1;
            while (!awvalid && n < 20) begin
                step();
                #1;
                n++;
            end
            chk("t6_aw_seen", 32'(awvalid), 32'd1);
        end
        step();
        step();
        step();
        chk("t6_beat3_wvalid", 32'(wvalid), 32'd1);
        chk("t6_beat3_wdata", wdata, 32'h0000_0602);
        rst = 1'b1;
        #1;
        chk("t6_rst_wvalid", 32'(wvalid), 32'd0);
        chk("t6_rst_awvalid", 32'(awvalid), 32'd0);
        chk("t6_rst_bready", 32'(bready), 32'd0);
        chk("t6_rst_wlast", 32'(wlast), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_push_ready", 32'(push_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        push_line(32'h6000_00c4, 32'h0000_0800);
        run_burst("t6_after", 32'h6000_00c0, 32'h0000_0800);
        #1;
        chk("t6_empty_end", 32'(empty), 32'd1);

`ifdef WB_FWD_EN
        // ---------------- forwarding from the youngest copy ----------------
        do_reset();
        begin
            logic [LINE_WORDS*32-1:0] l;
            l = '0;
            l[3*32 +: 32] = 32'h0000_0011;
            push_valid = 1'b1;
            push_addr  = 32'h0000_0100;
            push_data  = l;
            step();
            l[3*32 +: 32] = 32'h0000_0022;
            push_data  = l;
            step();
            push_valid = 1'b0;
            query_addr = 32'h0000_010c;
            #1;
            chk("fwd_hit", 32'(query_hit), 32'd1);
            chk("fwd_youngest", fwd_data, 32'h0000_0022);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
